// File: rtl/cpubus_mem_responder.sv
// Memory-side responder for the byte-serial CPU bus: gathers a 32-bit address and
// write word over four LSB-first edges, commits at the flag edge, then streams the word back.
module cpubus_mem_responder #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame,
    input  logic [7:0] a_in,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       busy,
    output logic       err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        FLAG,
        RDATA
    } state_t;

    state_t      state_q;
    logic [1:0]  idx_q;
    logic [31:0] addr_q;
    logic [31:0] wdat_q;
    logic [31:0] rdat_q;
    logic [7:0]  d_out_q;
    logic        d_oe_q;
    logic        busy_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH];

    logic          in_range;
    logic [AW-1:0] mem_idx;
    logic [31:0]   rd_word;
    logic          is_write;
    logic          wr_en;
    logic [31:0]   rdat_d;

    // Full-width compare so high address bytes can never alias onto a valid word.
    always_comb begin
        in_range = (addr_q < 32'(DEPTH));
        mem_idx  = addr_q[AW-1:0];
        rd_word  = in_range ? mem_q[mem_idx] : 32'h0;
        is_write = a_in[0];
        wr_en    = (state_q == FLAG) && !frame && is_write && in_range;
        if (!in_range) begin
            rdat_d = 32'h0;
        end else if (is_write) begin
            rdat_d = wdat_q;
        end else begin
            rdat_d = rd_word;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= 32'h0;
                end else if (wr_en && (mem_idx == AW'(gi))) begin
                    mem_q[gi] <= wdat_q;
                end
            end
        end
    endgenerate

    // A frame strobe in any state starts a fresh capture; commits happen only in FLAG.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            addr_q  <= 32'h0;
            wdat_q  <= 32'h0;
            rdat_q  <= 32'h0;
            d_out_q <= 8'h0;
            d_oe_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (frame) begin
                addr_q[7:0] <= a_in;
                wdat_q[7:0] <= d_in;
                state_q     <= ADDR;
                idx_q       <= 2'd1;
                busy_q      <= 1'b1;
                d_oe_q      <= 1'b0;
                d_out_q     <= 8'h0;
            end else begin
                case (state_q)
                    IDLE: begin
                        idx_q <= 2'd0;
                    end
                    ADDR: begin
                        addr_q[{idx_q, 3'b000} +: 8] <= a_in;
                        wdat_q[{idx_q, 3'b000} +: 8] <= d_in;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q <= FLAG;
                        end
                    end
                    FLAG: begin
                        rdat_q  <= rdat_d;
                        d_out_q <= rdat_d[7:0];
                        d_oe_q  <= 1'b1;
                        err_q   <= !in_range;
                        idx_q   <= 2'd1;
                        state_q <= RDATA;
                    end
                    RDATA: begin
                        // idx wraps to 0 after the top byte; that edge closes the frame.
                        if (idx_q == 2'd0) begin
                            d_out_q <= 8'h0;
                            d_oe_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            d_out_q <= rdat_q[{idx_q, 3'b000} +: 8];
                            idx_q   <= idx_q + 2'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        idx_q   <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign d_out = d_out_q;
    assign d_oe  = d_oe_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_cpubus_mem_responder.sv
// Directed plus randomized frames against a word-level memory model of the responder.
module tb_cpubus_mem_responder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame;
    logic [7:0] a_in;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [DEPTH];

    cpubus_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .frame (frame),
        .a_in  (a_in),
        .d_in  (d_in),
        .d_out (d_out),
        .d_oe  (d_oe),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    // Drives edges E0..last_edge of a frame; returns at the negedge after last_edge.
    task automatic run_frame(input logic [31:0] addr, input logic [31:0] wdata,
                             input bit wr, input int last_edge);
        logic [31:0] exp_word;
        bit inr;
        bit check_data;
        exp_word   = 32'h0;
        inr        = (addr < DEPTH);
        check_data = !(wr && !inr);
        $display("frame addr=%08h wr=%0d wdata=%08h edges=0..%0d", addr, wr, wdata, last_edge);
        for (int k = 0; k <= last_edge; k++) begin
            frame = (k == 0);
            if (k < 4) begin
                a_in = addr[8*k +: 8];
                d_in = wdata[8*k +: 8];
            end else if (k == 4) begin
                a_in = {7'($urandom), wr};
                d_in = 8'($urandom);
            end else begin
                a_in = 8'($urandom);
                d_in = 8'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            if (k == 4) begin
                if (!inr)    exp_word = 32'h0;
                else if (wr) exp_word = wdata;
                else         exp_word = model_mem[addr % DEPTH];
                if (wr && inr) model_mem[addr % DEPTH] = wdata;
            end
            check("busy", 32'(busy), 32'd1);
            check("d_oe", 32'(d_oe), 32'(k >= 4));
            if (k < 4) begin
                check("d_out_idle", 32'(d_out), 32'h0);
            end else if (check_data) begin
                check("d_out_byte", 32'(d_out), 32'(exp_word[8*(k-4) +: 8]));
            end
            check("err", 32'(err), 32'(k == 4 && !inr));
        end
    endtask

    task automatic idle_cycle();
        frame = 1'b0;
        a_in  = 8'($urandom);
        d_in  = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_d_oe", 32'(d_oe), 32'd0);
        check("idle_d_out", 32'(d_out), 32'h0);
        check("idle_err", 32'(err), 32'd0);
    endtask

    initial begin
        int le;
        logic [31:0] ra;
        rst_n = 1'b0;
        frame = 1'b0;
        a_in  = 8'h0;
        d_in  = 8'h0;
        clear_model();
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_d_oe", 32'(d_oe), 32'd0);
        check("rst_d_out", 32'(d_out), 32'h0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        idle_cycle();

        // Basic write then read-back.
        run_frame(32'd3, 32'hCAFEF00D, 1'b1, 7);
        idle_cycle();
        run_frame(32'd3, 32'h0, 1'b0, 7);
        idle_cycle();

        // Out-of-range read and write.
        run_frame(32'h0000_0010, 32'h0, 1'b0, 7);
        idle_cycle();
        run_frame(32'h0100_0002, 32'h1234_5678, 1'b1, 7);
        idle_cycle();
        run_frame(32'd2, 32'h0, 1'b0, 7);
        idle_cycle();

        // Restart at E2 of a write: nothing committed.
        run_frame(32'd5, 32'hDEAD_BEEF, 1'b1, 1);
        run_frame(32'd5, 32'h0, 1'b0, 7);
        idle_cycle();

        // Restart during RDATA: write already committed.
        run_frame(32'd4, 32'h0BAD_F00D, 1'b1, 5);
        run_frame(32'd4, 32'h0, 1'b0, 7);
        idle_cycle();

        // Back-to-back write then read.
        run_frame(32'd7, 32'h8765_4321, 1'b1, 7);
        run_frame(32'd7, 32'h0, 1'b0, 7);
        idle_cycle();

        // Reset landing at E3 of a write clears everything.
        run_frame(32'd9, 32'h5555_AAAA, 1'b1, 2);
        rst_n = 1'b0;
        #1;
        clear_model();
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_d_oe", 32'(d_oe), 32'd0);
        check("rst_mid_d_out", 32'(d_out), 32'h0);
        check("rst_mid_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        run_frame(32'd9, 32'h0, 1'b0, 7);
        idle_cycle();
        run_frame(32'd3, 32'h0, 1'b0, 7);
        idle_cycle();

        // Randomized frames, including aborts and back-to-back starts.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0:       ra = $urandom;
                1:       ra = 32'($urandom_range(DEPTH, DEPTH + 4));
                default: ra = 32'($urandom_range(0, DEPTH - 1));
            endcase
            le = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : 7;
            run_frame(ra, $urandom, 1'($urandom), le);
            if (le == 7 && $urandom_range(0, 1) == 1) idle_cycle();
        end
        run_frame(32'd1, 32'h0, 1'b0, 7);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpubus_mem_responder.md
# cpubus_mem_responder

Memory-side responder for the byte-serial CPU bus driven by `tt_um_jefloverockets_cpuhandler`. It captures the 32-bit address, the 32-bit write data and the read/write flag over 8-bit lanes. It then commits a write to, or returns a read word from, a small internal word memory. It sits on the board-level companion (FPGA/test harness) opposite the CPU handler and serves as the CPU's backing store.

## Interface
Parameters:
- `DEPTH`, default 16: number of 32-bit words. Valid word addresses are 0..DEPTH-1.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `frame`  in  1  frame-start strobe. Marks the cycle carrying address byte 0.
- `a_in`  in  8  address lane. Connects to the handler `uo_out`.
- `d_in`  in  8  write-data lane. Connects to the handler `uio_out`.
- `d_out`  out  8  read-data lane. Connects to the handler `uio_in`.
- `d_oe`  out  1  high while `d_out` is driven.
- `busy`  out  1  high while a frame is in progress.
- `err`  out  1  one-cycle pulse when a frame addresses a word index ≥ DEPTH.

## Operation
- Edges are named relative to the frame. E0 is the posedge at which `frame`=1 is sampled. E1, E2, … are the following posedges.
- FSM states are IDLE, ADDR, FLAG, RDATA.
  - An internal 2-bit byte index `idx` tracks position within ADDR and RDATA.
- At E0 (from IDLE):
  - `addr[7:0]`←`a_in` and `wdat[7:0]`←`d_in`.
  - Move to ADDR with idx=1.
- At E1–E3 (ADDR): capture `addr[8·idx+7:8·idx]` and `wdat[8·idx+7:8·idx]`.
  - Byte order is LSB first.
  - After E3, move to FLAG.
- At E4 (FLAG): sample `a_in[0]`. 1 = write, 0 = read. `a_in[7:1]` and `d_in` are ignored.
- In-range test uses the full 32-bit compare `addr < DEPTH`.
- Write at E4:
  - If in range, `mem[addr]`←`wdat`.
  - If out of range, the write is dropped and `err` pulses.
- Read at E4:
  - The word is latched into `rdat`: `mem[addr]` if in range, otherwise 32'h0 with `err` pulsed.
- Write frames still execute the RDATA phase so the frame length is fixed.
  - For a write, `rdat` is the value written, i.e. the new word. This is a read-back echo.
- At E4: `d_out`←`rdat[7:0]`, `d_oe`←1, move to RDATA.
  - At E5, E6, E7: `d_out`←`rdat[15:8]`, `rdat[23:16]`, `rdat[31:24]` respectively.
  - At E8: `d_out`←0, `d_oe`←0, return to IDLE.
- `busy` is 1 after E0 through E8, when it returns to 0.
- `frame`=1 sampled in any non-IDLE state is a restart.
  - That edge becomes a new E0: capture byte 0 and set `d_oe`←0, `d_out`←0.
  - An already-committed write (E4 passed) stays committed. A frame aborted before E4 leaves memory untouched.
- `frame` sampled at E8 starts the next frame immediately (back-to-back). `busy` stays 1.
- Memory is flops and is cleared on reset.

## Timing
- Reset (async assert, sync use after deassert):
  - State IDLE, idx=0.
  - `d_out`=0, `d_oe`=0, `busy`=0, `err`=0.
  - `addr`=`wdat`=`rdat`=0.
  - All memory words are 0.
- Reset mid-frame aborts immediately. No write occurs if the reset lands before E4.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Frame length is 9 edges (E0–E8).
- Read data is valid on `d_out` after E4..E7. The initiator samples it at E5..E8.
- Write-to-read latency: a read frame started at the E8 of a write frame returns the new data.
- `err` is high only for the cycle after E4.

## Test plan
- Write 0xCAFEF00D to address 3, then run a read frame to address 3 → `d_out` = 0x0D, 0xF0, 0xFE, 0xCA after E4..E7. `d_oe`=1 only for those four cycles. `err`=0.
- Read address 0x00000010 with DEPTH=16 → `err` pulses after E4. `d_out` bytes are all 0x00. Memory is unchanged.
- Write to address 0x01000002 (high byte set) → write dropped, `err`=1. A follow-up read of address 2 returns 0.
- Raise `frame` at E2 of a write to address 5, then complete a read of address 5 → returns 0x00000000 and the aborted write leaves no effect. The new frame's address is captured correctly.
- Back-to-back: `frame` at E8 of a write frame followed by a read of the same address → `busy` stays 1 across the boundary. The read returns the written word.
- Assert `rst_n`=0 at E3 of a write, then release → all outputs 0, state IDLE. A subsequent read of that address returns 0.
